// File: rtl/spi_flash_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_flash_pkg
// Purpose  : Shared state encoding and constants for the SPI flash burst reader.
// Revision : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_END   = 3'd5
    } state_e;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    // Chip-select high time (clk cycles) between the last slot and IDLE.
    localparam int T_CSH = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_reader_if.sv
`default_nettype none
// ============================================================================
// Interface: spi_flash_reader_if
// Purpose  : Core-side burst control, word stream and SPI flash pins.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_flash_reader_if #(
    parameter int ADDR_W = 24,
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
);
    logic              IN_start;
    logic [ADDR_W-1:0] IN_addr;
    logic [LEN_W-1:0]  IN_len;
    logic              IN_cancel;
    logic              OUT_busy;
    logic              OUT_done;
    logic              OUT_abort;
    logic [WORD_W-1:0] OUT_word;
    logic              OUT_valid;
    logic              IN_ready;
    logic              OUT_sclk;
    logic              OUT_cs;
    logic              OUT_mosi;
    logic              IN_miso;

    modport slave (
        input  IN_start, IN_addr, IN_len, IN_cancel, IN_ready, IN_miso,
        output OUT_busy, OUT_done, OUT_abort, OUT_word, OUT_valid,
               OUT_sclk, OUT_cs, OUT_mosi
    );

    modport master (
        output IN_start, IN_addr, IN_len, IN_cancel, IN_ready, IN_miso,
        input  OUT_busy, OUT_done, OUT_abort, OUT_word, OUT_valid,
               OUT_sclk, OUT_cs, OUT_mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_reader_bit_phase.sv
`default_nettype none
// ============================================================================
// Module   : spi_bit_phase
// Purpose  : Two-cycle SPI bit slot (L then H) with a stall gate held in L.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bit_phase (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic stall_i,
    output logic sclk_o,
    output logic slot_end_o
);
    logic phase_q;
    logic phase_d;

    always_comb begin
        phase_d = 1'b0;
        if (run_i && !phase_q) begin
            phase_d = !stall_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign sclk_o     = phase_q;
    assign slot_end_o = run_i & phase_q;

endmodule
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_reader
// Purpose  : SPI mode-0 flash burst reader streaming words over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int         ADDR_W = 24,
    parameter int         WORD_W = 32,
    parameter int         LEN_W  = 16,
    parameter logic [7:0] CMD    = CMD_READ,
    parameter int         DUMMY  = 0
) (
    input  logic              clk,
    input  logic              rst,
    spi_flash_reader_if.slave bus
);
    localparam int CNT_W = $clog2(max4(ADDR_W, WORD_W, DUMMY, 8)) + 1;
    localparam int TX_W  = 8 + ADDR_W;

    localparam logic [CNT_W-1:0] c_CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] c_ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] c_DUMMY_LAST = CNT_W'((DUMMY > 0) ? DUMMY - 1 : 0);
    localparam logic [CNT_W-1:0] c_WORD_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] c_CSH_LAST   = CNT_W'(T_CSH - 1);
    localparam state_e           c_AFTER_ADDR = (DUMMY > 0) ? ST_DUMMY : ST_DATA;

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [TX_W-1:0]    tx_q,     tx_d;
    logic [LEN_W-1:0]   rem_q,    rem_d;
    logic [WORD_W-1:0]  shreg_q,  shreg_d;
    logic [WORD_W-1:0]  word_q,   word_d;
    logic               mosi_q,   mosi_d;
    logic               cs_q,     cs_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               abort_q,  abort_d;
    logic               cancel_q, cancel_d;
    logic               load_q,   load_d;
    logic               valid_q,  valid_d;

    logic w_active;
    logic w_run;
    logic w_stall;
    logic w_sclk;
    logic w_slot_end;

    assign w_active = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                      (state_q == ST_DUMMY) || (state_q == ST_DATA);
    assign w_run    = w_active && !bus.IN_cancel;
    // Only the final bit of a word may be held, and only while the previous word is unaccepted.
    assign w_stall  = (state_q == ST_DATA) && (cnt_q == c_WORD_LAST) &&
                      valid_q && !bus.IN_ready;

    spi_bit_phase u_phase (
        .clk        (clk),
        .rst        (rst),
        .run_i      (w_run),
        .stall_i    (w_stall),
        .sclk_o     (w_sclk),
        .slot_end_o (w_slot_end)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        rem_d    = rem_q;
        shreg_d  = shreg_q;
        word_d   = word_q;
        mosi_d   = mosi_q;
        cs_d     = cs_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        cancel_d = cancel_q;
        load_d   = 1'b0;
        valid_d  = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.IN_start && !bus.IN_cancel) begin
                    if (bus.IN_len != '0) begin
                        state_d  = ST_CMD;
                        cnt_d    = '0;
                        tx_d     = {CMD, bus.IN_addr};
                        mosi_d   = CMD[7];
                        cs_d     = 1'b0;
                        busy_d   = 1'b1;
                        rem_d    = bus.IN_len;
                        cancel_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (bus.IN_cancel) begin
                    state_d  = ST_END;
                    cnt_d    = '0;
                    cs_d     = 1'b1;
                    mosi_d   = 1'b0;
                    cancel_d = 1'b1;
                end else if (w_slot_end) begin
                    // Zeros fill behind the command/address, so MOSI idles low afterwards.
                    tx_d   = {tx_q[TX_W-2:0], 1'b0};
                    mosi_d = tx_q[TX_W-2];
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (state_q == ST_CMD && cnt_q == c_CMD_LAST) begin
                        state_d = ST_ADDR;
                        cnt_d   = '0;
                    end else if (state_q == ST_ADDR && cnt_q == c_ADDR_LAST) begin
                        state_d = c_AFTER_ADDR;
                        cnt_d   = '0;
                    end else if (state_q == ST_DUMMY && cnt_q == c_DUMMY_LAST) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else if (state_q == ST_DATA) begin
                        shreg_d = {shreg_q[WORD_W-2:0], bus.IN_miso};
                        if (cnt_q == c_WORD_LAST) begin
                            cnt_d  = '0;
                            load_d = 1'b1;
                            rem_d  = rem_q - LEN_W'(1);
                            if (rem_q == LEN_W'(1)) begin
                                state_d = ST_END;
                                cs_d    = 1'b1;
                                mosi_d  = 1'b0;
                            end
                        end
                    end
                end
            end

            ST_END: begin
                mosi_d = 1'b0;
                if (cnt_q == c_CSH_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    abort_d = cancel_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output slot lives outside the FSM so a pending word survives END and IDLE.
        if (load_q) begin
            word_d  = shreg_q;
            valid_d = 1'b1;
        end else if (valid_q && bus.IN_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tx_q     <= '0;
            rem_q    <= '0;
            shreg_q  <= '0;
            word_q   <= '0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            cancel_q <= 1'b0;
            load_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            rem_q    <= rem_d;
            shreg_q  <= shreg_d;
            word_q   <= word_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            cancel_q <= cancel_d;
            load_q   <= load_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.OUT_sclk  = w_sclk;
    assign bus.OUT_cs    = cs_q;
    assign bus.OUT_mosi  = mosi_q;
    assign bus.OUT_busy  = busy_q;
    assign bus.OUT_done  = done_q;
    assign bus.OUT_abort = abort_q;
    assign bus.OUT_word  = word_q;
    assign bus.OUT_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_reader
// Purpose  : Directed/randomised bench with a behavioural SPI flash model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;
    import spi_flash_pkg::*;

    localparam int AW = 24;
    localparam int WW = 32;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_flash_reader_if #(.ADDR_W(AW), .WORD_W(WW), .LEN_W(LW)) b0 ();
    spi_flash_reader_if #(.ADDR_W(AW), .WORD_W(WW), .LEN_W(LW)) b1 ();

    spi_flash_reader #(.ADDR_W(AW), .WORD_W(WW), .LEN_W(LW), .CMD(CMD_READ), .DUMMY(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    spi_flash_reader #(.ADDR_W(AW), .WORD_W(WW), .LEN_W(LW), .CMD(CMD_FAST_READ), .DUMMY(8))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int checks   = 0;
    int failures = 0;

    // Flash model: byte array addressed by the low address byte, data shifted out MSB first.
    logic [7:0]  mem [256];
    int          bitn [2];
    logic [31:0] cap [2];
    int          dum_ones [2];
    logic        miso0 = 1'b0;
    logic        miso1 = 1'b0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    assign b0.IN_miso = miso0;
    assign b1.IN_miso = miso1;

    task automatic flash_edge(input int d, input logic mosi, input int dummy, output logic miso);
        int         k;
        int         di;
        logic [7:0] by;
        miso = 1'b0;
        k    = bitn[d];
        if (k < 32) begin
            cap[d] = {cap[d][30:0], mosi};
        end else if (k < 32 + dummy) begin
            if (mosi) dum_ones[d]++;
        end else begin
            di   = k - 32 - dummy;
            by   = mem[8'(cap[d][7:0] + 8'(di / 8))];
            miso = by[7 - (di % 8)];
        end
        bitn[d] = k + 1;
    endtask

    always @(negedge b0.OUT_cs) bitn[0] = 0;
    always @(negedge b1.OUT_cs) bitn[1] = 0;
    always @(posedge b0.OUT_sclk) if (!b0.OUT_cs) flash_edge(0, b0.OUT_mosi, 0, miso0);
    always @(posedge b1.OUT_sclk) if (!b1.OUT_cs) flash_edge(1, b1.OUT_mosi, 8, miso1);

    always @(negedge clk) begin
        if (b0.OUT_valid && b0.IN_ready) q0.push_back(b0.OUT_word);
        if (b1.OUT_valid && b1.IN_ready) q1.push_back(b1.OUT_word);
    end

    function automatic logic [31:0] exp_word(input logic [23:0] a, input int j);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            w = {w[23:0], mem[8'(a[7:0] + 8'(4 * j + i))]};
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int d, input logic [23:0] a, input logic [15:0] l);
        if (d == 0) begin
            b0.IN_addr = a; b0.IN_len = l; b0.IN_start = 1'b1;
        end else begin
            b1.IN_addr = a; b1.IN_len = l; b1.IN_start = 1'b1;
        end
        tick();
        b0.IN_start = 1'b0;
        b1.IN_start = 1'b0;
    endtask

    // Runs until done; first_v/ndone are cycle indices after the accept edge (-1 if never).
    task automatic run(input int d, input int limit, output int first_v, output int csh,
                       output int ndone, output logic ab);
        logic v, c, bz, dn;
        first_v = -1; csh = 0; ndone = -1; ab = 1'b0;
        for (int n = 0; n < limit; n++) begin
            v  = (d == 0) ? b0.OUT_valid : b1.OUT_valid;
            c  = (d == 0) ? b0.OUT_cs    : b1.OUT_cs;
            bz = (d == 0) ? b0.OUT_busy  : b1.OUT_busy;
            dn = (d == 0) ? b0.OUT_done  : b1.OUT_done;
            if (first_v < 0 && v) first_v = n;
            if (c && bz) csh++;
            if (dn) begin
                ndone = n;
                ab    = (d == 0) ? b0.OUT_abort : b1.OUT_abort;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [23:0] a;
        int          fv, csh, nd, cnt;
        logic        ab;

        rst = 1'b1;
        b0.IN_start = 0; b0.IN_addr = '0; b0.IN_len = '0; b0.IN_cancel = 0; b0.IN_ready = 0;
        b1.IN_start = 0; b1.IN_addr = '0; b1.IN_len = '0; b1.IN_cancel = 0; b1.IN_ready = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h45] = 8'hDE; mem[8'h46] = 8'hAD; mem[8'h47] = 8'hBE; mem[8'h48] = 8'hEF;
        dum_ones[0] = 0; dum_ones[1] = 0;
        tick(); tick();

        // Reset state
        chk("rst_cs",    b0.OUT_cs,    1);
        chk("rst_sclk",  b0.OUT_sclk,  0);
        chk("rst_mosi",  b0.OUT_mosi,  0);
        chk("rst_busy",  b0.OUT_busy,  0);
        chk("rst_done",  b0.OUT_done,  0);
        chk("rst_abort", b0.OUT_abort, 0);
        chk("rst_valid", b0.OUT_valid, 0);
        chk("rst_word",  b0.OUT_word,  0);
        rst = 1'b0;
        tick();

        // Single word read of 0x012345
        b0.IN_ready = 1'b1;
        start(0, 24'h012345, 16'd1);
        chk("t1_busy", b0.OUT_busy, 1);
        chk("t1_cs",   b0.OUT_cs,   0);
        run(0, 400, fv, csh, nd, ab);
        chk("t1_first_valid", fv, 129);
        chk("t1_done_cycle",  nd, 130);
        chk("t1_csh",         csh, 2);
        chk("t1_abort",       ab, 0);
        chk("t1_mosi_cmdaddr", cap[0], 32'h03012345);
        chk("t1_nwords", q0.size(), 1);
        if (q0.size() > 0) chk("t1_word", q0[0], 32'hDEADBEEF);
        chk("t1_busy_end", b0.OUT_busy, 0);

        // Four words with a consumer that stalls after the first
        q0.delete();
        b0.IN_ready = 1'b0;
        a = 24'($urandom);
        start(0, a, 16'd4);
        for (int n = 0; n < 260; n++) tick();
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (b0.OUT_sclk) cnt++;
            tick();
        end
        chk("t2_sclk_held", cnt, 0);
        chk("t2_stall_bit", bitn[0], 95);
        chk("t2_cs_low",    b0.OUT_cs, 0);
        chk("t2_pending",   b0.OUT_word, exp_word(a, 0));
        b0.IN_ready = 1'b1;
        run(0, 1000, fv, csh, nd, ab);
        chk("t2_done",   nd >= 0, 1);
        chk("t2_abort",  ab, 0);
        chk("t2_nwords", q0.size(), 4);
        for (int j = 0; j < 4 && j < q0.size(); j++) chk($sformatf("t2_word%0d", j), q0[j], exp_word(a, j));

        // Fast read with dummy cycles on the second instance
        b1.IN_ready = 1'b1;
        a = 24'($urandom);
        start(1, a, 16'd2);
        run(1, 600, fv, csh, nd, ab);
        chk("t3_first_valid", fv, 145);
        chk("t3_cmdaddr",     cap[1], {8'h0B, a});
        chk("t3_dummy_zero",  dum_ones[1], 0);
        chk("t3_abort",       ab, 0);
        chk("t3_nwords",      q1.size(), 2);
        for (int j = 0; j < 2 && j < q1.size(); j++) chk($sformatf("t3_word%0d", j), q1[j], exp_word(a, j));

        // Cancel during data bit 10 of word 1
        q0.delete();
        a = 24'($urandom);
        start(0, a, 16'd3);
        for (int n = 0; n < 200 && bitn[0] < 43; n++) tick();
        chk("t4_reached_bit10", bitn[0], 43);
        b0.IN_cancel = 1'b1;
        tick();
        b0.IN_cancel = 1'b0;
        chk("t4_cs_high", b0.OUT_cs,   1);
        chk("t4_sclk",    b0.OUT_sclk, 0);
        run(0, 50, fv, csh, nd, ab);
        chk("t4_done",    nd >= 0, 1);
        chk("t4_abort",   ab, 1);
        chk("t4_novalid", fv, -1);
        chk("t4_nwords",  q0.size(), 0);
        a = 24'($urandom);
        start(0, a, 16'd1);
        run(0, 400, fv, csh, nd, ab);
        chk("t4_restart_abort", ab, 0);
        chk("t4_restart_n",     q0.size(), 1);
        if (q0.size() > 0) chk("t4_restart_word", q0[0], exp_word(a, 0));

        // Zero-length request
        tick();
        start(0, 24'h000100, 16'd0);
        chk("t5_done",  b0.OUT_done,  1);
        chk("t5_abort", b0.OUT_abort, 0);
        chk("t5_busy",  b0.OUT_busy,  0);
        chk("t5_cs",    b0.OUT_cs,    1);
        tick();
        chk("t5_done_pulse", b0.OUT_done, 0);

        // Start while busy is ignored
        q0.delete();
        a = 24'($urandom);
        start(0, a, 16'd1);
        for (int n = 0; n < 20; n++) tick();
        start(0, a + 24'd64, 16'd3);
        run(0, 400, fv, csh, nd, ab);
        for (int n = 0; n < 10; n++) tick();
        chk("t5_busy_idle", b0.OUT_busy, 0);
        chk("t5_nwords",    q0.size(), 1);
        if (q0.size() > 0) chk("t5_word", q0[0], exp_word(a, 0));

        // Reset in the middle of the address phase
        start(0, 24'($urandom), 16'd2);
        for (int n = 0; n < 30; n++) tick();
        rst = 1'b1;
        tick();
        chk("t6_cs",   b0.OUT_cs,   1);
        chk("t6_sclk", b0.OUT_sclk, 0);
        chk("t6_busy", b0.OUT_busy, 0);
        chk("t6_done", b0.OUT_done, 0);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (b0.OUT_done) cnt++;
        end
        chk("t6_no_done", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Parametrised successor to the single-word EEPROM read controller: issues an SPI mode-0 read command (CMD, address, optional dummy bits), then streams IN_len words of WORD_W bits to the core.
- Generates its own SCLK at clk/2 so it can stall the flash when the consumer applies backpressure through a valid/ready handshake.
- Adds cancel-with-abort reporting, burst length, and a selectable command byte and dummy count.
- Sits between the external SPI flash pins and the core's bulk-load datapath.

Parameters:
- ADDR_W, 24, address bits sent MSB first (16, 24 or 32).
- WORD_W, 32, bits per output word (multiple of 8, 8..64).
- LEN_W, 16, width of the burst-length input (words).
- CMD, 8'h03, command byte (8'h0B = fast read).
- DUMMY, 0, dummy SCLK cycles after the address, MOSI held 0 (0..16).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- IN_start  in  1  request a burst; accepted only while OUT_busy=0.
- IN_addr  in  ADDR_W  start byte address, captured when IN_start is accepted.
- IN_len  in  LEN_W  number of words, captured when IN_start is accepted.
- IN_cancel  in  1  abort the current burst.
- OUT_busy  out  1  high from the accept cycle until the final IDLE re-entry.
- OUT_done  out  1  one-cycle pulse when a burst ends.
- OUT_abort  out  1  qualifies OUT_done: 1 means the burst ended by cancel.
- OUT_word  out  WORD_W  assembled word; the first received bit is the MSB.
- OUT_valid  out  1  OUT_word holds a word.
- IN_ready  in  1  consumer accepts the word when OUT_valid & IN_ready.
- OUT_sclk  out  1  SPI clock, registered, idles low.
- OUT_cs  out  1  chip select, active low, registered, idles high.
- OUT_mosi  out  1  registered serial data out.
- IN_miso  in  1  serial data in.

Behaviour:
- Reset: state IDLE. OUT_sclk=0, OUT_cs=1, OUT_mosi=0, OUT_busy=0, OUT_done=0, OUT_abort=0, OUT_valid=0, OUT_word=0.
- Bit slot: 2 clk cycles.
  - Phase L: OUT_sclk=0; OUT_mosi is updated on entry to L.
  - Phase H: OUT_sclk=1; IN_miso is sampled on the clk edge that ends H.
- FSM states: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> END -> IDLE.
- IDLE:
  - If IN_start=1 and IN_len!=0: capture addr and len, OUT_busy=1, OUT_cs=0 next cycle, enter CMD.
  - If IN_start=1 and IN_len=0: OUT_done=1 next cycle, OUT_cs is never asserted, remain in IDLE.
- CMD: 8 slots shifting CMD MSB first.
- ADDR: ADDR_W slots shifting IN_addr MSB first.
- DUMMY: DUMMY slots with MOSI=0; the state is skipped when DUMMY=0.
- DATA:
  - MOSI=0. Shift IN_miso into a WORD_W shift register; a word counter counts words.
  - Once a word's final bit is sampled, OUT_word/OUT_valid load on the following clk edge.
  - Then decrement the remaining-word count. At zero go to END; otherwise continue.
- Backpressure:
  - Before the H phase of any word's final bit, if OUT_valid=1 and IN_ready=0, hold OUT_sclk low (stay in L) until the pending word is accepted.
  - CS stays low during the stall.
  - The acceptance cycle itself may load the new word, so a continuously ready consumer sees one word every 2*WORD_W cycles.
- END:
  - OUT_sclk=0 and OUT_cs=1 for 2 clk cycles (t_CSH), then IDLE with OUT_busy=0.
  - OUT_done pulses in the IDLE-entry cycle.
  - The last word may still be pending; OUT_valid is held until it is accepted and is independent of busy.
- Cancel (IN_cancel=1 in any non-IDLE state):
  - Next cycle OUT_sclk=0, OUT_cs=1, enter END.
  - A partially assembled word is discarded; an already-valid word is kept.
  - OUT_done and OUT_abort pulse together on IDLE entry.
  - Cancel in IDLE is ignored. Cancel has priority over start.
- IN_start while busy: ignored, no queueing.
- Counters:
  - The bit counter is sized $clog2(max(ADDR_W, WORD_W, DUMMY, 8))+1.
  - The remaining-word counter is LEN_W wide.
  - Length 2^LEN_W-1 must work with no wrap.
- Timing of the first word: OUT_valid rises exactly 2*(8+ADDR_W+DUMMY+WORD_W)+1 clk cycles after the start-accept edge, with no stall.
- rst mid-burst: immediate return to reset values on the next edge; OUT_done does not pulse.

Decomposition:
- spi_flash_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, DATA, END);
  - command constants CMD_READ=8'h03 and CMD_FAST_READ=8'h0B;
  - the T_CSH=2 constant.
- One sub-module, spi_bit_phase, owns the L/H phase toggle and stall gate:
  - Inputs: run, stall.
  - Outputs: sclk, slot_end (the last cycle of a slot).
- The top module holds the FSM, shift registers, counters and output register.

Test Plan:
- CMD=03, ADDR_W=24, WORD_W=32, DUMMY=0. start with addr=0x012345, len=1, ready=1, model returns 0xDEADBEEF:
  - MOSI carries 0x03 then 0x012345;
  - OUT_word=0xDEADBEEF valid at cycle 129 after accept;
  - done=1, abort=0; CS high for 2 cycles before idle.
- len=4, ready held 0 after the first word: SCLK stops low before bit 31 of word 2; releasing ready yields words 2..4 in order, no loss or duplication.
- CMD=0B, DUMMY=8, len=2: 8 MOSI-zero slots follow the address; first valid at 2*(8+24+8+32)+1=145 cycles.
- IN_cancel during DATA bit 10 of word 1: CS high next cycle, no OUT_valid, done=abort=1; a following start works normally.
- start with len=0: done pulse on the next cycle, CS never low, busy stays 0. start while busy is ignored.
- rst asserted mid-ADDR: next cycle CS=1, SCLK=0, busy=0, no done pulse.
